sram_access_arbiter: RTL and testbench

// Shares the single asynchronous SRAM between two requesters: the CPU control path (port cpu_*) and an

---
 rtl/sram_access_arbiter_if.sv | 34 +++
 rtl/sram_access_arbiter.sv | 162 ++++++++++++++++
 tb/tb_sram_access_arbiter.sv | 357 +++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/sram_access_arbiter_if.sv
// Requester-side bundle for sram_access_arbiter: CPU and auxiliary request/ack/data ports.
// master = requesters, slave = arbiter.
interface sram_access_arbiter_if #(
    parameter int unsigned ADDR_W = 20,
    parameter int unsigned DATA_W = 16
);
    logic              cpu_req;
    logic              cpu_we;
    logic [ADDR_W-1:0] cpu_addr;
    logic [DATA_W-1:0] cpu_wdata;
    logic              cpu_ack;
    logic [DATA_W-1:0] cpu_rdata;

    logic              aux_req;
    logic              aux_we;
    logic [ADDR_W-1:0] aux_addr;
    logic [DATA_W-1:0] aux_wdata;
    logic              aux_ack;
    logic [DATA_W-1:0] aux_rdata;

    modport master (
        output cpu_req, cpu_we, cpu_addr, cpu_wdata,
        input  cpu_ack, cpu_rdata,
        output aux_req, aux_we, aux_addr, aux_wdata,
        input  aux_ack, aux_rdata
    );

    modport slave (
        input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
        output cpu_ack, cpu_rdata,
        input  aux_req, aux_we, aux_addr, aux_wdata,
        output aux_ack, aux_rdata
    );
endinterface

// File: rtl/sram_access_arbiter.sv
// Two-port arbiter sequencing single accesses to an asynchronous SRAM (IDLE -> ACCESS -> DONE).
// Define SRAM_ARB_CPU_PRIORITY_EN for fixed CPU priority; default is round robin.
module sram_access_arbiter #(
    parameter int unsigned ADDR_W      = 20,
    parameter int unsigned DATA_W      = 16,
    parameter int unsigned WAIT_CYCLES = 2
) (
    input  logic                  Clk,
    input  logic                  Reset_n,
    sram_access_arbiter_if.slave  req_if,
    output logic                  Mem_CE,
    output logic                  Mem_UB,
    output logic                  Mem_LB,
    output logic                  Mem_OE,
    output logic                  Mem_WE,
    output logic [ADDR_W-1:0]     sram_addr,
    output logic [DATA_W-1:0]     sram_wdata,
    output logic                  sram_drive,
    input  logic [DATA_W-1:0]     sram_rdata
);

    localparam int unsigned CntW = $clog2(WAIT_CYCLES + 1);

    typedef enum logic [1:0] {StIdle, StAccess, StDone} state_e;

    state_e            state_q, state_d;
    logic [CntW-1:0]   cnt_q, cnt_d;
    logic              grant_aux_q, grant_aux_d;
    logic              we_q, we_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [DATA_W-1:0] cpu_rdata_q, cpu_rdata_d;
    logic [DATA_W-1:0] aux_rdata_q, aux_rdata_d;
    logic              pick_aux;

`ifdef SRAM_ARB_CPU_PRIORITY_EN
    always_comb begin
        pick_aux = !req_if.cpu_req;
    end
`else
    logic last_aux_q, last_aux_d;

    // On contention the port not granted last wins.
    always_comb begin
        if (req_if.cpu_req && req_if.aux_req) begin
            pick_aux = !last_aux_q;
        end else begin
            pick_aux = !req_if.cpu_req;
        end
    end
`endif

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        grant_aux_d = grant_aux_q;
        we_d        = we_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        cpu_rdata_d = cpu_rdata_q;
        aux_rdata_d = aux_rdata_q;
`ifndef SRAM_ARB_CPU_PRIORITY_EN
        last_aux_d  = last_aux_q;
`endif
        unique case (state_q)
            StIdle: begin
                if (req_if.cpu_req || req_if.aux_req) begin
                    state_d     = StAccess;
                    cnt_d       = CntW'(WAIT_CYCLES - 1);
                    grant_aux_d = pick_aux;
`ifndef SRAM_ARB_CPU_PRIORITY_EN
                    last_aux_d  = pick_aux;
`endif
                    if (pick_aux) begin
                        we_d    = req_if.aux_we;
                        addr_d  = req_if.aux_addr;
                        wdata_d = req_if.aux_wdata;
                    end else begin
                        we_d    = req_if.cpu_we;
                        addr_d  = req_if.cpu_addr;
                        wdata_d = req_if.cpu_wdata;
                    end
                end
            end
            StAccess: begin
                if (cnt_q == '0) begin
                    state_d = StDone;
                    // Read data is sampled on the final edge the strobes are low.
                    if (!we_q) begin
                        if (grant_aux_q) begin
                            aux_rdata_d = sram_rdata;
                        end else begin
                            cpu_rdata_d = sram_rdata;
                        end
                    end
                end else begin
                    cnt_d = cnt_q - CntW'(1);
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state_q     <= StIdle;
            cnt_q       <= '0;
            grant_aux_q <= 1'b0;
            we_q        <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            cpu_rdata_q <= '0;
            aux_rdata_q <= '0;
`ifndef SRAM_ARB_CPU_PRIORITY_EN
            last_aux_q  <= 1'b1;
`endif
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            grant_aux_q <= grant_aux_d;
            we_q        <= we_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            cpu_rdata_q <= cpu_rdata_d;
            aux_rdata_q <= aux_rdata_d;
`ifndef SRAM_ARB_CPU_PRIORITY_EN
            last_aux_q  <= last_aux_d;
`endif
        end
    end

    // Strobes decode straight from registered state so reset releases them immediately.
    always_comb begin
        Mem_CE     = 1'b1;
        Mem_UB     = 1'b1;
        Mem_LB     = 1'b1;
        Mem_OE     = 1'b1;
        Mem_WE     = 1'b1;
        sram_drive = 1'b0;
        if (state_q == StAccess) begin
            Mem_CE     = 1'b0;
            Mem_UB     = 1'b0;
            Mem_LB     = 1'b0;
            Mem_OE     = we_q;
            Mem_WE     = !we_q;
            sram_drive = we_q;
        end
    end

    assign sram_addr        = addr_q;
    assign sram_wdata       = wdata_q;
    assign req_if.cpu_ack   = (state_q == StDone) && !grant_aux_q;
    assign req_if.aux_ack   = (state_q == StDone) && grant_aux_q;
    assign req_if.cpu_rdata = cpu_rdata_q;
    assign req_if.aux_rdata = aux_rdata_q;

endmodule

// File: tb/tb_sram_access_arbiter.sv
// Scoreboard bench for sram_access_arbiter; expected acks are queued as requests are issued.
// Honours SRAM_ARB_CPU_PRIORITY_EN in the arbitration scenario.
module tb_sram_access_arbiter;

    localparam int unsigned ADDR_W = 20;
    localparam int unsigned DATA_W = 16;

    logic              Clk = 1'b0;
    logic              Reset_n;
    logic              Mem_CE, Mem_UB, Mem_LB, Mem_OE, Mem_WE;
    logic [ADDR_W-1:0] sram_addr;
    logic [DATA_W-1:0] sram_wdata;
    logic              sram_drive;
    logic [DATA_W-1:0] sram_rdata;
    bit                use_fixed;
    logic [DATA_W-1:0] fixed_val;

    always #5 Clk = ~Clk;

    sram_access_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

    sram_access_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .WAIT_CYCLES(2)) dut (
        .Clk        (Clk),
        .Reset_n    (Reset_n),
        .req_if     (bus),
        .Mem_CE     (Mem_CE),
        .Mem_UB     (Mem_UB),
        .Mem_LB     (Mem_LB),
        .Mem_OE     (Mem_OE),
        .Mem_WE     (Mem_WE),
        .sram_addr  (sram_addr),
        .sram_wdata (sram_wdata),
        .sram_drive (sram_drive),
        .sram_rdata (sram_rdata)
    );

    // SRAM model: address-derived data unless a fixed value is forced.
    assign sram_rdata = use_fixed ? fixed_val : (sram_addr[15:0] ^ 16'h5A5A);

    typedef struct {
        bit                is_aux;
        bit                is_write;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] wdata;
        logic [DATA_W-1:0] rdata;
    } exp_t;

    exp_t              sb[$];
    int                n_checks = 0;
    int                n_pass   = 0;
    logic [DATA_W-1:0] exp_cpu_rdata = '0;
    logic [DATA_W-1:0] exp_aux_rdata = '0;

    task automatic push_exp(input bit is_aux, input bit is_write, input logic [ADDR_W-1:0] addr,
                            input logic [DATA_W-1:0] wdata);
        exp_t e;
        e.is_aux   = is_aux;
        e.is_write = is_write;
        e.addr     = addr;
        e.wdata    = wdata;
        if (!is_write) begin
            if (is_aux) exp_aux_rdata = addr[15:0] ^ 16'h5A5A;
            else        exp_cpu_rdata = addr[15:0] ^ 16'h5A5A;
        end
        e.rdata = is_aux ? exp_aux_rdata : exp_cpu_rdata;
        sb.push_back(e);
    endtask

    // Observes one access up to its ack; cyc = -1 if no ack arrives in budget.
    task automatic wait_ack(output int cyc, output int oe_n, output int we_n, output int drv_n,
                            output bit got_cpu, output bit got_aux,
                            output logic [ADDR_W-1:0] addr_seen,
                            output logic [DATA_W-1:0] wdata_seen);
        bit first = 1'b1;
        cyc = 0; oe_n = 0; we_n = 0; drv_n = 0;
        got_cpu = 1'b0; got_aux = 1'b0;
        addr_seen = 'x; wdata_seen = 'x;
        for (int i = 0; i < 20; i++) begin
            @(negedge Clk);
            cyc++;
            if (!Mem_CE && first) begin
                addr_seen  = sram_addr;
                wdata_seen = sram_wdata;
                first      = 1'b0;
            end
            if (!Mem_OE) oe_n++;
            if (!Mem_WE) we_n++;
            if (sram_drive) drv_n++;
            if (bus.cpu_ack || bus.aux_ack) begin
                got_cpu = bus.cpu_ack;
                got_aux = bus.aux_ack;
                return;
            end
        end
        cyc = -1;
    endtask

    task automatic test_reset();
        Reset_n = 1'b0;
        #12;
        n_checks++;
        if ({Mem_CE, Mem_UB, Mem_LB, Mem_OE, Mem_WE} !== 5'b11111)
            $display("FAIL reset_strobes: got %b expected 11111",
                     {Mem_CE, Mem_UB, Mem_LB, Mem_OE, Mem_WE});
        else n_pass++;
        n_checks++;
        if ({bus.cpu_ack, bus.aux_ack, sram_drive} !== 3'b000)
            $display("FAIL reset_ack_drive: got %b expected 000",
                     {bus.cpu_ack, bus.aux_ack, sram_drive});
        else n_pass++;
        n_checks++;
        if ({sram_addr, sram_wdata, bus.cpu_rdata, bus.aux_rdata} !== '0)
            $display("FAIL reset_regs: got addr %0h wdata %0h cpu_rdata %0h aux_rdata %0h expected 0",
                     sram_addr, sram_wdata, bus.cpu_rdata, bus.aux_rdata);
        else n_pass++;
        @(negedge Clk);
        Reset_n = 1'b1;
        exp_cpu_rdata = '0;
        exp_aux_rdata = '0;
    endtask

    task automatic test_cpu_read();
        int cyc, oe_n, we_n, drv_n;
        bit gc, ga;
        logic [ADDR_W-1:0] a;
        logic [DATA_W-1:0] w;
        exp_t e;
        repeat (2) @(negedge Clk);
        use_fixed = 1'b1;
        fixed_val = 16'hBEEF;
        bus.cpu_req = 1'b1; bus.cpu_we = 1'b0; bus.cpu_addr = 20'h00010;
        push_exp(1'b0, 1'b0, 20'h00010, '0);
        exp_cpu_rdata = 16'hBEEF;
        sb[$].rdata   = 16'hBEEF;
        wait_ack(cyc, oe_n, we_n, drv_n, gc, ga, a, w);
        bus.cpu_req = 1'b0;
        e = sb.pop_front();
        n_checks++;
        if (cyc !== 3) $display("FAIL cpu_read_latency: got %0d expected 3", cyc);
        else n_pass++;
        n_checks++;
        if (oe_n !== 2 || we_n !== 0)
            $display("FAIL cpu_read_strobes: got oe %0d we %0d expected oe 2 we 0", oe_n, we_n);
        else n_pass++;
        n_checks++;
        if ({gc, ga} !== {!e.is_aux, e.is_aux} || a !== e.addr)
            $display("FAIL cpu_read_grant: got ack %b addr %0h expected %b addr %0h",
                     {gc, ga}, a, {!e.is_aux, e.is_aux}, e.addr);
        else n_pass++;
        n_checks++;
        if (bus.cpu_rdata !== e.rdata)
            $display("FAIL cpu_read_data: got %0h expected %0h", bus.cpu_rdata, e.rdata);
        else n_pass++;
        use_fixed = 1'b0;
    endtask

    task automatic test_aux_write();
        int cyc, oe_n, we_n, drv_n;
        bit gc, ga;
        logic [ADDR_W-1:0] a;
        logic [DATA_W-1:0] w;
        exp_t e;
        repeat (2) @(negedge Clk);
        bus.aux_req = 1'b1; bus.aux_we = 1'b1;
        bus.aux_addr = 20'h0ABCD; bus.aux_wdata = 16'h1234;
        push_exp(1'b1, 1'b1, 20'h0ABCD, 16'h1234);
        wait_ack(cyc, oe_n, we_n, drv_n, gc, ga, a, w);
        bus.aux_req = 1'b0;
        e = sb.pop_front();
        n_checks++;
        if (cyc !== 3 || we_n !== 2 || oe_n !== 0 || drv_n !== 2)
            $display("FAIL aux_write_timing: got cyc %0d we %0d oe %0d drv %0d expected 3 2 0 2",
                     cyc, we_n, oe_n, drv_n);
        else n_pass++;
        n_checks++;
        if ({gc, ga} !== {!e.is_aux, e.is_aux} || a !== e.addr || w !== e.wdata)
            $display("FAIL aux_write_bus: got ack %b addr %0h wdata %0h expected %b %0h %0h",
                     {gc, ga}, a, w, {!e.is_aux, e.is_aux}, e.addr, e.wdata);
        else n_pass++;
        n_checks++;
        if (bus.aux_rdata !== e.rdata || bus.cpu_rdata !== exp_cpu_rdata)
            $display("FAIL aux_write_rdata_hold: got aux %0h cpu %0h expected %0h %0h",
                     bus.aux_rdata, bus.cpu_rdata, e.rdata, exp_cpu_rdata);
        else n_pass++;
    endtask

    task automatic test_ignore_changes();
        int cyc, oe_n, we_n, drv_n;
        bit gc, ga;
        logic [ADDR_W-1:0] a;
        logic [DATA_W-1:0] w;
        exp_t e;
        repeat (2) @(negedge Clk);
        use_fixed = 1'b1;
        fixed_val = 16'h7E57;
        bus.cpu_req = 1'b1; bus.cpu_we = 1'b0; bus.cpu_addr = 20'h00321;
        push_exp(1'b0, 1'b0, 20'h00321, '0);
        exp_cpu_rdata = 16'h7E57;
        sb[$].rdata   = 16'h7E57;
        @(negedge Clk);
        n_checks++;
        if (Mem_OE !== 1'b0 || sram_addr !== 20'h00321)
            $display("FAIL ignore_first_cycle: got oe %b addr %0h expected 0 321", Mem_OE, sram_addr);
        else n_pass++;
        bus.cpu_req = 1'b0; bus.cpu_we = 1'b1;
        bus.cpu_addr = 20'h0FFFF; bus.cpu_wdata = 16'hDEAD;
        wait_ack(cyc, oe_n, we_n, drv_n, gc, ga, a, w);
        e = sb.pop_front();
        n_checks++;
        if (cyc !== 2 || oe_n !== 1 || we_n !== 0 || !gc || ga)
            $display("FAIL ignore_complete: got cyc %0d oe %0d we %0d ack %b expected 2 1 0 10",
                     cyc, oe_n, we_n, {gc, ga});
        else n_pass++;
        n_checks++;
        if (a !== e.addr || bus.cpu_rdata !== e.rdata)
            $display("FAIL ignore_latched: got addr %0h rdata %0h expected %0h %0h",
                     a, bus.cpu_rdata, e.addr, e.rdata);
        else n_pass++;
        use_fixed = 1'b0;
    endtask

    task automatic test_mid_reset();
        int acks = 0;
        repeat (2) @(negedge Clk);
        bus.aux_req = 1'b1; bus.aux_we = 1'b1;
        bus.aux_addr = 20'h00055; bus.aux_wdata = 16'hA5A5;
        @(negedge Clk);
        n_checks++;
        if (sram_drive !== 1'b1 || Mem_WE !== 1'b0)
            $display("FAIL midreset_active: got drive %b we %b expected 1 0", sram_drive, Mem_WE);
        else n_pass++;
        #1 Reset_n = 1'b0;
        #1;
        n_checks++;
        if ({Mem_CE, Mem_UB, Mem_LB, Mem_OE, Mem_WE, sram_drive, bus.cpu_ack, bus.aux_ack}
            !== 8'b11111000)
            $display("FAIL midreset_release: got %b expected 11111000",
                     {Mem_CE, Mem_UB, Mem_LB, Mem_OE, Mem_WE, sram_drive, bus.cpu_ack, bus.aux_ack});
        else n_pass++;
        bus.aux_req = 1'b0;
        @(negedge Clk);
        Reset_n = 1'b1;
        exp_cpu_rdata = '0;
        exp_aux_rdata = '0;
        for (int i = 0; i < 6; i++) begin
            @(negedge Clk);
            if (bus.cpu_ack || bus.aux_ack || !Mem_CE) acks++;
        end
        n_checks++;
        if (acks !== 0) $display("FAIL midreset_no_ack: got %0d activity cycles expected 0", acks);
        else n_pass++;
        n_checks++;
        if (bus.cpu_rdata !== exp_cpu_rdata)
            $display("FAIL midreset_rdata: got %0h expected %0h", bus.cpu_rdata, exp_cpu_rdata);
        else n_pass++;
    endtask

    task automatic test_arbitration();
        int cyc, oe_n, we_n, drv_n;
        bit gc, ga;
        logic [ADDR_W-1:0] a;
        logic [DATA_W-1:0] w;
        exp_t e;
        Reset_n = 1'b0;
        @(negedge Clk);
        Reset_n = 1'b1;
        exp_cpu_rdata = '0;
        exp_aux_rdata = '0;
        @(negedge Clk);
        bus.cpu_req = 1'b1; bus.cpu_we = 1'b0; bus.cpu_addr = 20'h01111;
        bus.aux_req = 1'b1; bus.aux_we = 1'b0; bus.aux_addr = 20'h02222;
`ifdef SRAM_ARB_CPU_PRIORITY_EN
        for (int i = 0; i < 4; i++) push_exp(1'b0, 1'b0, 20'h01111, '0);
        push_exp(1'b1, 1'b0, 20'h02222, '0);
`else
        for (int i = 0; i < 4; i++) push_exp(i[0], 1'b0, i[0] ? 20'h02222 : 20'h01111, '0);
`endif
        for (int i = 0; i < 5; i++) begin
`ifndef SRAM_ARB_CPU_PRIORITY_EN
            if (i == 4) break;
`endif
            wait_ack(cyc, oe_n, we_n, drv_n, gc, ga, a, w);
            e = sb.pop_front();
            if (i == 3) bus.cpu_req = 1'b0;
            if (i == 4) bus.aux_req = 1'b0;
            n_checks++;
            if (cyc !== ((i == 0) ? 3 : 4))
                $display("FAIL arb_spacing_%0d: got %0d expected %0d", i, cyc, (i == 0) ? 3 : 4);
            else n_pass++;
            n_checks++;
            if ({gc, ga} !== {!e.is_aux, e.is_aux} || a !== e.addr)
                $display("FAIL arb_grant_%0d: got ack %b addr %0h expected %b %0h",
                         i, {gc, ga}, a, {!e.is_aux, e.is_aux}, e.addr);
            else n_pass++;
            n_checks++;
            if ((e.is_aux ? bus.aux_rdata : bus.cpu_rdata) !== e.rdata)
                $display("FAIL arb_rdata_%0d: got %0h expected %0h",
                         i, e.is_aux ? bus.aux_rdata : bus.cpu_rdata, e.rdata);
            else n_pass++;
        end
        bus.cpu_req = 1'b0;
        bus.aux_req = 1'b0;
        @(negedge Clk);
        n_checks++;
        if (bus.cpu_ack !== 1'b0 || bus.aux_ack !== 1'b0)
            $display("FAIL arb_ack_width: got %b expected 00", {bus.cpu_ack, bus.aux_ack});
        else n_pass++;
    endtask

    task automatic test_back_to_back();
        int cyc, oe_n, we_n, drv_n;
        bit gc, ga;
        logic [ADDR_W-1:0] a;
        logic [DATA_W-1:0] w;
        exp_t e;
        repeat (2) @(negedge Clk);
        for (int i = 0; i < 4; i++) begin
            bus.cpu_req   = 1'b1;
            bus.cpu_we    = i[0];
            bus.cpu_addr  = ADDR_W'($urandom_range(0, 20'hFFFFF));
            bus.cpu_wdata = DATA_W'($urandom);
            push_exp(1'b0, i[0], bus.cpu_addr, bus.cpu_wdata);
            wait_ack(cyc, oe_n, we_n, drv_n, gc, ga, a, w);
            e = sb.pop_front();
            n_checks++;
            if (cyc !== ((i == 0) ? 3 : 4) || !gc || ga || a !== e.addr)
                $display("FAIL b2b_access_%0d: got cyc %0d ack %b addr %0h expected %0d 10 %0h",
                         i, cyc, {gc, ga}, a, (i == 0) ? 3 : 4, e.addr);
            else n_pass++;
            n_checks++;
            if (e.is_write && (w !== e.wdata || drv_n !== 2 || we_n !== 2))
                $display("FAIL b2b_write_%0d: got wdata %0h drv %0d we %0d expected %0h 2 2",
                         i, w, drv_n, we_n, e.wdata);
            else if (bus.cpu_rdata !== e.rdata)
                $display("FAIL b2b_rdata_%0d: got %0h expected %0h", i, bus.cpu_rdata, e.rdata);
            else n_pass++;
        end
        bus.cpu_req = 1'b0;
    endtask

    initial begin
        use_fixed = 1'b0;
        fixed_val = '0;
        bus.cpu_req = 1'b0; bus.cpu_we = 1'b0; bus.cpu_addr = '0; bus.cpu_wdata = '0;
        bus.aux_req = 1'b0; bus.aux_we = 1'b0; bus.aux_addr = '0; bus.aux_wdata = '0;
        test_reset();
        test_cpu_read();
        test_aux_write();
        test_ignore_changes();
        test_mid_reset();
        test_arbitration();
        test_back_to_back();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
